// File: rtl/i2c_pkg2202.sv
// Shared definitions for the i2c_target2202 responder: FSM state encoding,
// R/W bit meanings and the address-match rule.
package i2c_pkg2202;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    AACK = 3'd2,
    WRX  = 3'd3,
    WACK = 3'd4,
    TXB  = 3'd5,
    RACK = 3'd6,
    IGNR = 3'd7
  } state_t;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // The general-call address is never claimed, even if own address is 0.
  function automatic logic addr_match(input logic [6:0] addr, input logic [6:0] own);
    return (addr == own) && (addr != 7'h00);
  endfunction

endpackage

// File: rtl/i2c_sync_edge2202.sv
// SCL/SDA synchroniser with bus event detection (edges, START, STOP).
// Optional 3-sample majority filter when I2C_TGT_GLITCH_FILTER_EN is defined.
module i2c_sync_edge2202 #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic srst,
  input  logic i_scl,
  input  logic i_sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  localparam int MSB = SYNC_STAGES - 1;

  logic [MSB:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic         scl_f, sda_f;
  logic         scl_d1_q, scl_d1_d, sda_d1_q, sda_d1_d;
  logic         rise_q, rise_d, fall_q, fall_d, start_q, start_d, stop_q, stop_d;

  always_comb begin
    scl_sync_d = {scl_sync_q[MSB-1:0], i_scl};
    sda_sync_d = {sda_sync_q[MSB-1:0], i_sda};
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
    end
  end

`ifdef I2C_TGT_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
  logic       scl_filt_q, scl_filt_d, sda_filt_q, sda_filt_d;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_comb begin
    scl_hist_d = {scl_hist_q[0], scl_sync_q[MSB]};
    sda_hist_d = {sda_hist_q[0], sda_sync_q[MSB]};
    scl_filt_d = maj3(scl_sync_q[MSB], scl_hist_q[0], scl_hist_q[1]);
    sda_filt_d = maj3(sda_sync_q[MSB], sda_hist_q[0], sda_hist_q[1]);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
      scl_filt_q <= scl_filt_d;
      sda_filt_q <= sda_filt_d;
    end
  end

  assign scl_f = scl_filt_q;
  assign sda_f = sda_filt_q;
`else
  assign scl_f = scl_sync_q[MSB];
  assign sda_f = sda_sync_q[MSB];
`endif

  // Events are registered so they line up with the delayed copies exported as sda_s.
  always_comb begin
    scl_d1_d = scl_f;
    sda_d1_d = sda_f;
    rise_d   = scl_f & ~scl_d1_q;
    fall_d   = ~scl_f & scl_d1_q;
    start_d  = scl_f & scl_d1_q & ~sda_f & sda_d1_q;
    stop_d   = scl_f & scl_d1_q & sda_f & ~sda_d1_q;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      scl_d1_q <= 1'b1;
      sda_d1_q <= 1'b1;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      scl_d1_q <= scl_d1_d;
      sda_d1_q <= sda_d1_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
    end
  end

  assign sda_s     = sda_d1_q;
  assign scl_rise  = rise_q;
  assign scl_fall  = fall_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;

endmodule

// File: rtl/i2c_target2202.sv
// I2C target answering one fixed 7-bit address; open-drain SDA via o_sda_oe.
// Build option: I2C_TGT_GLITCH_FILTER_EN enables the input majority filter.
module i2c_target2202
  import i2c_pkg2202::*;
#(
  parameter logic [6:0] TGT_ADDR    = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i_cclk,
  input  logic       i_rst,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  output logic [7:0] o_rxdata,
  output logic       o_rx_valid,
  input  logic [7:0] i_txdata,
  output logic       o_tx_req,
  output logic       o_busy,
  output logic       o_rw
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_sync_edge2202 #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (i_cclk),
    .srst     (i_rst),
    .i_scl    (i_scl),
    .i_sda    (i_sda),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d, rxdata_q, rxdata_d;
  logic [2:0] cnt_q, cnt_d;
  logic       done_q, done_d, sda_oe_q, sda_oe_d, rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d, busy_q, busy_d, rw_q, rw_d;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    sda_oe_d   = sda_oe_q;
    rxdata_d   = rxdata_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    busy_d     = busy_q;
    rw_d       = rw_q;
    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      cnt_d    = 3'd0;
      done_d   = 1'b0;
    end else if (start_det) begin
      state_d  = ADDR;
      sda_oe_d = 1'b0;
      cnt_d    = 3'd0;
      done_d   = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise && !done_q) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rw_d = sda_s;
              if (addr_match(shift_q[6:0], TGT_ADDR)) begin
                done_d = 1'b1;
              end else begin
                state_d = IGNR;
                busy_d  = 1'b0;
              end
            end
          end else if (scl_fall && done_q) begin
            done_d   = 1'b0;
            sda_oe_d = 1'b1;
            busy_d   = 1'b1;
            state_d  = AACK;
            if (rw_q == RW_READ) begin
              tx_req_d = 1'b1;
              shift_d  = i_txdata;
            end
          end
        end
        AACK: begin
          if (scl_fall) begin
            cnt_d  = 3'd0;
            done_d = 1'b0;
            if (rw_q == RW_READ) begin
              sda_oe_d = ~shift_q[7];
              state_d  = TXB;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = WRX;
            end
          end
        end
        WRX: begin
          if (scl_rise && !done_q) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rxdata_d   = {shift_q[6:0], sda_s};
              rx_valid_d = 1'b1;
              done_d     = 1'b1;
            end
          end else if (scl_fall && done_q) begin
            sda_oe_d = 1'b1;
            done_d   = 1'b0;
            state_d  = WACK;
          end
        end
        WACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = WRX;
          end
        end
        TXB: begin
          // The bit just driven ends on this fall; present the next one.
          if (scl_fall) begin
            shift_d = {shift_q[6:0], 1'b0};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              done_d   = 1'b0;
              state_d  = RACK;
            end else begin
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        RACK: begin
          if (scl_rise && !done_q) begin
            if (!sda_s) done_d = 1'b1;
            else        state_d = IGNR;
          end else if (scl_fall && done_q) begin
            tx_req_d = 1'b1;
            shift_d  = i_txdata;
            sda_oe_d = ~i_txdata[7];
            cnt_d    = 3'd0;
            done_d   = 1'b0;
            state_d  = TXB;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_cclk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      shift_q    <= 8'h00;
      cnt_q      <= 3'd0;
      done_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      rxdata_q   <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      sda_oe_q   <= sda_oe_d;
      rxdata_q   <= rxdata_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
    end
  end

  assign o_sda_oe   = sda_oe_q;
  assign o_rxdata   = rxdata_q;
  assign o_rx_valid = rx_valid_q;
  assign o_tx_req   = tx_req_q;
  assign o_busy     = busy_q;
  assign o_rw       = rw_q;

endmodule

// File: tb/tb_i2c_target2202.sv
// Bench for i2c_target2202: a bit-banged I2C controller drives the bus,
// table-driven and random transactions are checked against a byte-level model.
module tb_i2c_target2202;

  localparam logic [6:0] TGT = 7'h42;
  localparam int         Q   = 8;   // i_cclk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_drv, sda_drv, sda_bus;
  logic       sda_oe, rx_valid, tx_req, busy, rw;
  logic [7:0] rxdata, txdata;

  always #5 clk = ~clk;

  assign sda_bus = sda_drv & ~sda_oe;

  i2c_target2202 #(.TGT_ADDR(TGT), .SYNC_STAGES(2)) dut (
    .i_cclk    (clk),
    .i_rst     (rst),
    .i_scl     (scl_drv),
    .i_sda     (sda_bus),
    .o_sda_oe  (sda_oe),
    .o_rxdata  (rxdata),
    .o_rx_valid(rx_valid),
    .i_txdata  (txdata),
    .o_tx_req  (tx_req),
    .o_busy    (busy),
    .o_rw      (rw)
  );

  // Byte source for reads: each o_tx_req consumes the next entry.
  int         rx_cnt = 0;
  int         tx_cnt = 0;
  logic [7:0] tx_mem [0:255];
  assign txdata = tx_mem[tx_cnt[7:0]];

  always @(posedge clk) begin
    if (rx_valid) rx_cnt <= rx_cnt + 1;
    if (tx_req)   tx_cnt <= tx_cnt + 1;
  end

  int         n_checks = 0;
  int         n_fail   = 0;
  int         txn_no   = 0;
  logic [7:0] model_rx = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Works both from idle bus and as a repeated START with SCL low.
  task automatic i2c_start();
    sda_drv = 1'b1; tick(Q);
    scl_drv = 1'b1; tick(Q);
    sda_drv = 1'b0; tick(Q);
    scl_drv = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; tick(Q);
    scl_drv = 1'b1; tick(Q);
    sda_drv = 1'b1; tick(Q);
  endtask

  task automatic clk_bit(input logic b, input logic glitch, output logic line, output logic oe);
    sda_drv = b;    tick(Q);
    scl_drv = 1'b1; tick(Q);
    line = sda_bus;
    oe   = sda_oe;
    if (glitch) begin
      scl_drv = 1'b0; tick(1);
      scl_drv = 1'b1;
    end
    tick(Q);
    scl_drv = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input int glitch_bit, output logic ack, output logic oe9);
    logic l, o;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], glitch_bit == i, l, o);
    clk_bit(1'b1, 1'b0, l, o);
    ack = ~l;
    oe9 = o;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic l, o;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, 1'b0, l, o);
      d[i] = l;
    end
    clk_bit(nack, 1'b0, l, o);
  endtask

  // One complete transfer: START, address, n data bytes, STOP.
  task automatic do_txn(input logic rd, input logic [7:0] addr, input int n, input logic [23:0] data,
                        input logic exp_ack, input logic [7:0] exp_last, input string tag);
    int         rx0, tx0;
    logic       ack, oe9;
    logic [7:0] b;
    rx0 = rx_cnt;
    tx0 = tx_cnt;
    if (rd) for (int k = 0; k < n; k++) tx_mem[(tx_cnt + k) & 255] = data[8*k +: 8];
    i2c_start();
    write_byte(addr, -1, ack, oe9);
    check({tag, " addr ack"}, {31'd0, ack}, {31'd0, exp_ack});
    check({tag, " addr oe 9th clk"}, {31'd0, oe9}, {31'd0, exp_ack});
    check({tag, " busy after addr"}, {31'd0, busy}, {31'd0, exp_ack});
    if (exp_ack) check({tag, " rw"}, {31'd0, rw}, {31'd0, addr[0]});
    if (!rd) begin
      for (int k = 0; k < n; k++) begin
        write_byte(data[8*k +: 8], -1, ack, oe9);
        check({tag, " data ack"}, {31'd0, ack}, {31'd0, exp_ack});
        check({tag, " data oe 9th clk"}, {31'd0, oe9}, {31'd0, exp_ack});
      end
      check({tag, " rx_valid pulses"}, rx_cnt - rx0, exp_ack ? n : 0);
    end else if (exp_ack) begin
      for (int k = 0; k < n; k++) begin
        read_byte(k == n - 1, b);
        check({tag, " read byte"}, {24'd0, b}, {24'd0, data[8*k +: 8]});
      end
      check({tag, " tx_req pulses"}, tx_cnt - tx0, n);
      check({tag, " sda released after nack"}, {31'd0, sda_oe}, 32'd0);
    end
    i2c_stop();
    tick(Q);
    check({tag, " rxdata"}, {24'd0, rxdata}, {24'd0, exp_last});
    check({tag, " busy after stop"}, {31'd0, busy}, 32'd0);
    $display("txn %0d %s: %s addr=0x%02h bytes=%0d ack=%0b rxdata=0x%02h", txn_no, tag,
             rd ? "read " : "write", addr, n, ack, rxdata);
    txn_no++;
  endtask

  typedef struct packed {
    logic        rd;
    logic [7:0]  addr;
    logic [1:0]  n;
    logic [23:0] data;
    logic        exp_ack;
    logic [7:0]  exp_last;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic       ack, oe9, l, o;
    logic [7:0] b;
    logic [6:0] a7;
    logic       rd, exp_ack;
    int         n, rx0;
    logic [23:0] data;

    vecs[0] = '{1'b0, 8'h84, 2'd1, 24'h0000A5, 1'b1, 8'hA5};
    vecs[1] = '{1'b1, 8'h85, 2'd2, 24'h00F03C, 1'b1, 8'hA5};
    vecs[2] = '{1'b0, 8'h90, 2'd1, 24'h000011, 1'b0, 8'hA5};
    vecs[3] = '{1'b0, 8'h00, 2'd1, 24'h000022, 1'b0, 8'hA5};
    vecs[4] = '{1'b0, 8'h84, 2'd3, 24'h030201, 1'b1, 8'h03};
    vecs[5] = '{1'b1, 8'h91, 2'd1, 24'h000099, 1'b0, 8'h03};
    vecs[6] = '{1'b0, 8'h86, 2'd1, 24'h000077, 1'b0, 8'h03};
    vecs[7] = '{1'b1, 8'h85, 2'd1, 24'h000055, 1'b1, 8'h03};

    rst = 1'b1; scl_drv = 1'b1; sda_drv = 1'b1;
    tick(5);
    check("reset sda_oe", {31'd0, sda_oe}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset rw", {31'd0, rw}, 32'd0);
    check("reset rxdata", {24'd0, rxdata}, 32'd0);
    check("reset rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset tx_req", {31'd0, tx_req}, 32'd0);
    rst = 1'b0;
    tick(5);

    for (int i = 0; i < 8; i++)
      do_txn(vecs[i].rd, vecs[i].addr, int'(vecs[i].n), vecs[i].data,
             vecs[i].exp_ack, vecs[i].exp_last, "table");
    model_rx = 8'h03;

    // Repeated START: write then read without an intervening STOP.
    i2c_start();
    write_byte(8'h84, -1, ack, oe9);
    check("rs write addr ack", {31'd0, ack}, 32'd1);
    check("rs rw write", {31'd0, rw}, 32'd0);
    write_byte(8'h01, -1, ack, oe9);
    check("rs data ack", {31'd0, ack}, 32'd1);
    tx_mem[tx_cnt & 255] = 8'hC3;
    i2c_start();
    check("rs busy after Sr", {31'd0, busy}, 32'd1);
    write_byte(8'h85, -1, ack, oe9);
    check("rs read addr ack", {31'd0, ack}, 32'd1);
    check("rs rw read", {31'd0, rw}, 32'd1);
    check("rs busy after addr", {31'd0, busy}, 32'd1);
    read_byte(1'b1, b);
    check("rs read byte", {24'd0, b}, 32'hC3);
    i2c_stop();
    tick(Q);
    check("rs rxdata", {24'd0, rxdata}, 32'h01);
    check("rs busy after stop", {31'd0, busy}, 32'd0);
    $display("txn %0d repeated-start: write 0x01 then read 0x%02h", txn_no, b);
    txn_no++;
    model_rx = 8'h01;

    // Reset in the middle of a read byte (during its 4th bit).
    tx_mem[tx_cnt & 255] = 8'hA5;
    i2c_start();
    write_byte(8'h85, -1, ack, oe9);
    check("mid-rst addr ack", {31'd0, ack}, 32'd1);
    b = 8'h00;
    for (int i = 7; i >= 5; i--) begin
      clk_bit(1'b1, 1'b0, l, o);
      b[i] = l;
    end
    check("mid-rst first 3 bits", {29'd0, b[7:5]}, 32'd5);
    sda_drv = 1'b1; tick(Q);
    scl_drv = 1'b1; tick(Q / 2);
    check("mid-rst 4th bit driven low", {31'd0, sda_oe}, 32'd1);
    rst = 1'b1; tick(1);
    rst = 1'b0;
    check("mid-rst sda_oe", {31'd0, sda_oe}, 32'd0);
    check("mid-rst busy", {31'd0, busy}, 32'd0);
    check("mid-rst rw", {31'd0, rw}, 32'd0);
    check("mid-rst rxdata", {24'd0, rxdata}, 32'd0);
    check("mid-rst tx_req", {31'd0, tx_req}, 32'd0);
    check("mid-rst rx_valid", {31'd0, rx_valid}, 32'd0);
    $display("txn %0d reset-mid-read: bits before reset=%03b", txn_no, b[7:5]);
    txn_no++;
    scl_drv = 1'b0; tick(Q);
    i2c_stop();
    tick(Q);
    model_rx = 8'h00;
    do_txn(1'b0, 8'h84, 1, 24'h00005C, 1'b1, 8'h5C, "post-reset");
    model_rx = 8'h5C;

`ifdef I2C_TGT_GLITCH_FILTER_EN
    rx0 = rx_cnt;
    i2c_start();
    write_byte(8'h84, -1, ack, oe9);
    check("glitch addr ack", {31'd0, ack}, 32'd1);
    write_byte(8'h5A, 3, ack, oe9);
    check("glitch data ack", {31'd0, ack}, 32'd1);
    check("glitch rx_valid pulses", rx_cnt - rx0, 32'd1);
    i2c_stop();
    tick(Q);
    check("glitch rxdata", {24'd0, rxdata}, 32'h5A);
    $display("txn %0d glitch: rxdata=0x%02h", txn_no, rxdata);
    txn_no++;
    model_rx = 8'h5A;
`endif

    // Random transfers checked against the byte-level model.
    for (int t = 0; t < 8; t++) begin
      a7      = ($urandom_range(0, 1) == 1) ? TGT : 7'($urandom_range(0, 127));
      rd      = 1'($urandom_range(0, 1));
      n       = $urandom_range(1, 3);
      data    = 24'($urandom);
      exp_ack = (a7 == TGT) && (a7 != 7'h00);
      if (!rd && exp_ack) model_rx = data[8*(n-1) +: 8];
      do_txn(rd, {a7, rd}, n, data, exp_ack, model_rx, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
